pipeline_scoreboard: RTL and testbench

Parametrised pipeline hazard/forwarding controller for the CPU datapath. It generalises the fixed EX/MEM/WB hazard, forwarding and stall glue to `NSTAGES` post-decode stages with per-instruction result-ready stage. It tracks every in-flight writer in a shift-register scoreboard and decides when ID issues, stalls or flushes. It registers forwarding selects into EX, counts hazard stalls, and tracks halt retirement.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/pipeline_scoreboard_if.sv | 42 ++++
 rtl/pipeline_scoreboard_hazard_match.sv | 48 ++++
 rtl/pipeline_scoreboard.sv | 114 +++++++++++
 tb/tb_pipeline_scoreboard.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline scoreboard
package pipeline_pkg;

  // Entries are sized for the widest legal configuration (REGW<=8, NSTAGES<=8).
  localparam int REGW_MAX = 8;
  localparam int STGW_MAX = 4;

  typedef logic [STGW_MAX-1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = '0;

  localparam logic [REGW_MAX-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [REGW_MAX-1:0] wsel;
    logic [STGW_MAX-1:0] rdy;
    logic                halt;
  } sb_entry_t;

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// rtl/pipeline_scoreboard_if.sv - ID/hazard handshake bundle between datapath and scoreboard
interface pipeline_scoreboard_if #(
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int STGW    = $clog2(NSTAGES+1)
);
  logic               id_valid;
  logic [REGW-1:0]    id_rs;
  logic [REGW-1:0]    id_rt;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               id_wen;
  logic [REGW-1:0]    id_wsel;
  logic [STGW-1:0]    id_rdy;
  logic               id_halt;
  logic               redirect;
  logic               mem_wait;
  logic               issue;
  logic               stall_id;
  logic               ifid_en;
  logic               ifid_flush;
  logic               stage_en;
  logic [NSTAGES-1:0] stage_valid;
  logic [STGW-1:0]    ex_fwd_a;
  logic [STGW-1:0]    ex_fwd_b;
  logic [31:0]        stall_cnt;
  logic               halt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_wsel,
           id_rdy, id_halt, redirect, mem_wait,
    input  issue, stall_id, ifid_en, ifid_flush, stage_en, stage_valid,
           ex_fwd_a, ex_fwd_b, stall_cnt, halt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_wsel,
           id_rdy, id_halt, redirect, mem_wait,
    output issue, stall_id, ifid_en, ifid_flush, stage_en, stage_valid,
           ex_fwd_a, ex_fwd_b, stall_cnt, halt
  );
endinterface

// File: rtl/pipeline_scoreboard_hazard_match.sv
// rtl/pipeline_scoreboard_hazard_match.sv - youngest in-flight writer match for one source operand
module hazard_match
  import pipeline_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int FWD_EN  = 1,
  localparam int STGW   = $clog2(NSTAGES+1)
) (
  input  logic [NSTAGES-1:0]               wr,
  input  logic [NSTAGES-1:0][REGW_MAX-1:0] wsel,
  input  logic [NSTAGES-1:0][STGW_MAX-1:0] rdy,
  input  logic [REGW-1:0]                  src,
  input  logic                             used,
  output logic                             hit,
  output logic [STGW-1:0]                  k,
  output logic                             hazard,
  output logic [STGW-1:0]                  sel
);
  logic [REGW_MAX-1:0] src_ext;
  logic [STGW_MAX-1:0] k_rdy;

  always_comb begin
    src_ext = REGW_MAX'(src);
    hit     = 1'b0;
    k       = '0;
    k_rdy   = '0;
    // Scan oldest to youngest so the lowest matching index wins.
    for (int i = NSTAGES-1; i >= 0; i--) begin
      if (wr[i] && used && (wsel[i] == src_ext) && (src_ext != REG_ZERO)) begin
        hit   = 1'b1;
        k     = STGW'(i);
        k_rdy = rdy[i];
      end
    end

    if (FWD_EN != 0) begin
      hazard = hit && (k_rdy > STGW_MAX'(k));
    end else begin
      hazard = hit && (k < STGW'(NSTAGES-1));
    end

    sel = '0;
    if ((FWD_EN != 0) && hit && !hazard && ((int'(k) + 1) < NSTAGES)) begin
      sel = k + STGW'(1);
    end
  end
endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - in-flight writer scoreboard deciding issue, stall, flush and EX forwarding
module pipeline_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int FWD_EN  = 1,
  localparam int STGW   = $clog2(NSTAGES+1)
) (
  input logic                   CLK,
  input logic                   nRST,
  pipeline_scoreboard_if.slave  bus
);
  sb_entry_t [NSTAGES-1:0] sb_q, sb_d;
  logic [STGW-1:0]         fwd_a_q, fwd_a_d;
  logic [STGW-1:0]         fwd_b_q, fwd_b_d;
  logic [31:0]             stall_cnt_q, stall_cnt_d;
  logic                    halted_issue_q, halted_issue_d;
  logic                    halt_q, halt_d;

  logic [NSTAGES-1:0]               sb_wr;
  logic [NSTAGES-1:0][REGW_MAX-1:0] sb_wsel;
  logic [NSTAGES-1:0][STGW_MAX-1:0] sb_rdy;
  logic [NSTAGES-1:0]               stage_valid;
  sb_entry_t                        id_entry;

  logic            rs_hit, rt_hit, rs_haz, rt_haz;
  logic [STGW-1:0] rs_k, rt_k, rs_sel, rt_sel;
  logic            stall_id, issue;

  always_comb begin
    for (int i = 0; i < NSTAGES; i++) begin
      sb_wr[i]       = sb_q[i].valid & sb_q[i].wen;
      sb_wsel[i]     = sb_q[i].wsel;
      sb_rdy[i]      = sb_q[i].rdy;
      stage_valid[i] = sb_q[i].valid;
    end
    id_entry = '{valid: 1'b1, wen: bus.id_wen, wsel: REGW_MAX'(bus.id_wsel),
                 rdy: STGW_MAX'(bus.id_rdy), halt: bus.id_halt};
  end

  hazard_match #(.NSTAGES(NSTAGES), .REGW(REGW), .FWD_EN(FWD_EN)) u_match_rs (
    .wr(sb_wr), .wsel(sb_wsel), .rdy(sb_rdy), .src(bus.id_rs), .used(bus.id_rs_used),
    .hit(rs_hit), .k(rs_k), .hazard(rs_haz), .sel(rs_sel)
  );

  hazard_match #(.NSTAGES(NSTAGES), .REGW(REGW), .FWD_EN(FWD_EN)) u_match_rt (
    .wr(sb_wr), .wsel(sb_wsel), .rdy(sb_rdy), .src(bus.id_rt), .used(bus.id_rt_used),
    .hit(rt_hit), .k(rt_k), .hazard(rt_haz), .sel(rt_sel)
  );

  assign stall_id = bus.id_valid & (rs_haz | rt_haz) & ~halted_issue_q;
  assign issue    = bus.id_valid & ~stall_id & ~bus.mem_wait & ~halted_issue_q;

  assign bus.stall_id    = stall_id;
  assign bus.issue       = issue;
  assign bus.stage_en    = ~bus.mem_wait;
  assign bus.ifid_en     = ~bus.mem_wait & ~stall_id & ~halted_issue_q;
  assign bus.ifid_flush  = bus.redirect & issue;
  assign bus.stage_valid = stage_valid;
  assign bus.ex_fwd_a    = fwd_a_q;
  assign bus.ex_fwd_b    = fwd_b_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.halt        = halt_q;

  // mem_wait freezes every piece of state; otherwise the scoreboard shifts each cycle.
  always_comb begin
    sb_d           = sb_q;
    fwd_a_d        = fwd_a_q;
    fwd_b_d        = fwd_b_q;
    stall_cnt_d    = stall_cnt_q;
    halted_issue_d = halted_issue_q;
    halt_d         = halt_q;
    if (!bus.mem_wait) begin
      sb_d[0] = issue ? id_entry : '0;
      for (int i = 1; i < NSTAGES; i++) begin
        sb_d[i] = sb_q[i-1];
      end
      fwd_a_d = issue ? rs_sel : STGW'(FWD_RF);
      fwd_b_d = issue ? rt_sel : STGW'(FWD_RF);
      if (stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (sb_q[NSTAGES-1].valid && sb_q[NSTAGES-1].halt) begin
        halt_d = 1'b1;
      end
    end
    if (issue && bus.id_halt) begin
      halted_issue_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sb_q           <= '0;
      fwd_a_q        <= '0;
      fwd_b_q        <= '0;
      stall_cnt_q    <= '0;
      halted_issue_q <= 1'b0;
      halt_q         <= 1'b0;
    end else begin
      sb_q           <= sb_d;
      fwd_a_q        <= fwd_a_d;
      fwd_b_q        <= fwd_b_d;
      stall_cnt_q    <= stall_cnt_d;
      halted_issue_q <= halted_issue_d;
      halt_q         <= halt_d;
    end
  end

  // Only the forwarding selects leave the matchers; hit/k stay internal.
  logic unused_match;
  assign unused_match = ^{rs_hit, rt_hit, rs_k, rt_k};
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - scoreboard bench for FWD_EN=0 (dut 0) and FWD_EN=1 (dut 1)
module tb_pipeline_scoreboard;
  localparam int N  = 3;
  localparam int RW = 5;
  localparam int SW = 2;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic          id_valid_v[2], id_rs_used_v[2], id_rt_used_v[2], id_wen_v[2];
  logic          id_halt_v[2], redirect_v[2], mem_wait_v[2];
  logic [RW-1:0] id_rs_v[2], id_rt_v[2], id_wsel_v[2];
  logic [SW-1:0] id_rdy_v[2];

  logic [1:0]         issue_w, stall_w, flush_w, ifid_en_w, halt_w;
  logic [1:0][SW-1:0] fa_w, fb_w;
  logic [1:0][N-1:0]  sv_w;
  logic [1:0][31:0]   cnt_w;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipeline_scoreboard_if #(.NSTAGES(N), .REGW(RW)) bus ();
    pipeline_scoreboard #(.NSTAGES(N), .REGW(RW), .FWD_EN(g)) u_dut (
      .CLK(CLK), .nRST(nRST), .bus(bus.slave)
    );
    assign bus.id_valid   = id_valid_v[g];
    assign bus.id_rs      = id_rs_v[g];
    assign bus.id_rt      = id_rt_v[g];
    assign bus.id_rs_used = id_rs_used_v[g];
    assign bus.id_rt_used = id_rt_used_v[g];
    assign bus.id_wen     = id_wen_v[g];
    assign bus.id_wsel    = id_wsel_v[g];
    assign bus.id_rdy     = id_rdy_v[g];
    assign bus.id_halt    = id_halt_v[g];
    assign bus.redirect   = redirect_v[g];
    assign bus.mem_wait   = mem_wait_v[g];
    assign issue_w[g]     = bus.issue;
    assign stall_w[g]     = bus.stall_id;
    assign flush_w[g]     = bus.ifid_flush;
    assign ifid_en_w[g]   = bus.ifid_en;
    assign halt_w[g]      = bus.halt;
    assign fa_w[g]        = bus.ex_fwd_a;
    assign fb_w[g]        = bus.ex_fwd_b;
    assign sv_w[g]        = bus.stage_valid;
    assign cnt_w[g]       = bus.stall_cnt;
  end

  typedef struct {
    int          dut;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        flush;
    int          stalls;
    logic [31:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  int   ncmp = 0;
  int   nfail = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  // Monitor: pops one expectation per issue, checks EX-cycle outputs one cycle later.
  int   stalls[2] = '{0, 0};
  logic pend[2]   = '{1'b0, 1'b0};
  rec_t pend_rec[2];

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        chk("ex_fwd_a", d, 32'(fa_w[d]), 32'(pend_rec[d].fa));
        chk("ex_fwd_b", d, 32'(fb_w[d]), 32'(pend_rec[d].fb));
        chk("stall_cnt", d, cnt_w[d], pend_rec[d].cnt);
        pend[d] = 1'b0;
      end
      if (nRST) begin
        if (stall_w[d] && !mem_wait_v[d]) stalls[d]++;
        if (issue_w[d]) begin
          if (exp_q.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL unexpected_issue dut%0d: issue=1 with nothing expected", d);
          end else begin
            rec_t r;
            r = exp_q.pop_front();
            chk("issue_dut", d, 32'(d), 32'(r.dut));
            chk("stall_cycles", d, 32'(stalls[d]), 32'(r.stalls));
            chk("ifid_flush", d, 32'(flush_w[d]), 32'(r.flush));
            pend_rec[d] = r;
            pend[d]     = 1'b1;
          end
          stalls[d] = 0;
        end
      end
    end
  end

  task automatic send(input int d, input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] used,
                      input logic wen, input logic [4:0] wsel, input logic [1:0] rdy,
                      input logic hlt, input logic redir, input logic [1:0] efa, input logic [1:0] efb,
                      input logic eflush, input int estalls, input int ecnt, input int mw,
                      input logic [2:0] esv);
    rec_t r;
    logic got;
    r.dut = d; r.fa = efa; r.fb = efb; r.flush = eflush; r.stalls = estalls; r.cnt = 32'(ecnt);
    exp_q.push_back(r);
    id_rs_v[d] = rs; id_rt_v[d] = rt; id_rs_used_v[d] = used[1]; id_rt_used_v[d] = used[0];
    id_wen_v[d] = wen; id_wsel_v[d] = wsel; id_rdy_v[d] = rdy; id_halt_v[d] = hlt;
    redirect_v[d] = redir; id_valid_v[d] = 1'b1;
    if (mw > 0) begin
      mem_wait_v[d] = 1'b1;
      for (int c = 0; c < mw; c++) begin
        @(negedge CLK);
        chk("freeze_stage_valid", d, 32'(sv_w[d]), 32'(esv));
        chk("freeze_stall_cnt", d, cnt_w[d], 32'(ecnt - estalls));
        chk("freeze_issue", d, 32'(issue_w[d]), 32'd0);
        @(posedge CLK); #1;
      end
      mem_wait_v[d] = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      got = issue_w[d];
      if (!got && redir) chk("flush_while_stalled", d, 32'(flush_w[d]), 32'd0);
      @(posedge CLK); #1;
    end
    if (!got) begin
      ncmp++;
      nfail++;
      $display("FAIL issue_timeout dut%0d: issue=0 after 20 cycles, required 1", d);
    end
    id_valid_v[d] = 1'b0;
    redirect_v[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      id_valid_v[d] = 0; id_rs_used_v[d] = 0; id_rt_used_v[d] = 0; id_wen_v[d] = 0;
      id_halt_v[d] = 0; redirect_v[d] = 0; mem_wait_v[d] = 0;
      id_rs_v[d] = 0; id_rt_v[d] = 0; id_wsel_v[d] = 0; id_rdy_v[d] = 0;
    end
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_stage_valid", d, 32'(sv_w[d]), 32'd0);
      chk("reset_stall_cnt", d, cnt_w[d], 32'd0);
      chk("reset_halt", d, 32'(halt_w[d]), 32'd0);
      chk("reset_fwd_a", d, 32'(fa_w[d]), 32'd0);
    end
    nRST = 1'b1;
    @(posedge CLK); #1;

    //   d  rs rt used wen wsel rdy hlt rdr fa fb fl st cnt mw sv
    send(1, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);  // add r1
    send(1, 1, 1, 2'b11, 1, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'b000);  // add r2,r1,r1
    send(1, 2, 0, 2'b10, 1, 3, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000);  // lw r3,(r2)
    send(1, 3, 0, 2'b11, 1, 4, 0, 0, 0, 2, 0, 0, 1, 1, 0, 3'b000);  // sub r4,r3,r0
    send(1, 0, 0, 2'b00, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 3'b000);  // lw r5
    send(1, 5, 5, 2'b11, 1, 6, 0, 0, 0, 2, 2, 0, 1, 2, 3, 3'b011);  // add r6,r5,r5 + mem_wait
    send(1, 1, 2, 2'b11, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 0, 3'b000);  // beq taken, unstalled
    send(1, 0, 0, 2'b00, 1, 7, 1, 0, 0, 0, 0, 0, 0, 2, 0, 3'b000);  // lw r7
    send(1, 7, 0, 2'b11, 0, 0, 0, 0, 1, 2, 0, 1, 1, 3, 0, 3'b000);  // beq r7,r0 taken, stalled
    send(1, 0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 3'b000);  // lw r0
    send(1, 0, 0, 2'b11, 1, 8, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3'b000);  // add r8,r0,r0
    send(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 3, 0, 3'b000);  // halt

    id_halt_v[1] = 1'b0; id_wen_v[1] = 1'b1; id_wsel_v[1] = 9; id_valid_v[1] = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge CLK);
      chk("halted_no_issue", 1, 32'(issue_w[1]), 32'd0);
      chk("halt_flag", 1, 32'(halt_w[1]), (j == 4) ? 32'd1 : 32'd0);
    end
    chk("halted_ifid_en", 1, 32'(ifid_en_w[1]), 32'd0);
    id_valid_v[1] = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("midreset_stall_cnt", 1, cnt_w[1], 32'd0);
    chk("midreset_halt", 1, 32'(halt_w[1]), 32'd0);
    chk("midreset_stage_valid", 1, 32'(sv_w[1]), 32'd0);
    #3;
    nRST = 1'b1;
    @(posedge CLK); #1;
    send(1, 1, 1, 2'b11, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);  // issues again after reset

    send(0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);  // add r1
    send(0, 1, 1, 2'b11, 1, 2, 0, 0, 0, 0, 0, 0, 2, 2, 0, 3'b000);  // add r2,r1,r1: 2 stalls
    send(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3'b000);  // add r0
    send(0, 0, 0, 2'b11, 1, 3, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3'b000);  // add r3,r0,r0
    send(0, 2, 2, 2'b11, 1, 4, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3'b000);  // r2 in last stage

    repeat (3) @(negedge CLK);
    chk("queue_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
